// File: rtl/inst_fetch.sv
// inst_fetch: instruction prefetcher with one outstanding memory read and a DEPTH-entry FIFO
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               pulse: begin fetching at BOOT_PC
//   i_redirect/_pc        flush FIFO and restart fetch at a new word address
//   i_consume             CPU takes the head instruction
//   o_inst/_valid/_pc     head of FIFO (zeros when empty)
//   o_imem_req/_addr      one-cycle read request (addr zero when idle)
//   i_imem_rvalid/_rdata  read response, one or more cycles after the request
module inst_fetch #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] BOOT_PC = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_consume,
  output logic [31:0] o_inst,
  output logic        o_inst_valid,
  output logic [31:0] o_inst_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;
  state_t          r_state, w_state_nx;
  logic [31:0]     r_pc, w_pc_nx;
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_data [DEPTH];
  logic [31:0]     r_ipc  [DEPTH];
  logic            w_push, w_pop, w_flush, w_req, w_full, w_empty;
  assign w_full  = r_cnt == CW'(DEPTH);
  assign w_empty = r_cnt == '0;
  // redirect wins over both pop and push in the same cycle
  assign w_pop   = i_consume && !w_empty && !w_flush && r_state != S_IDLE;
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_push     = 1'b0;
    w_flush    = 1'b0;
    w_req      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nx = S_REQ;
        w_pc_nx    = BOOT_PC;
      end
      S_REQ: if (i_redirect) begin
        w_flush = 1'b1;
        w_pc_nx = i_redirect_pc;
      end else if (!w_full) begin
        w_req      = 1'b1;
        w_state_nx = S_WAIT;
      end
      S_WAIT: if (i_redirect) begin
        w_flush    = 1'b1;
        w_pc_nx    = i_redirect_pc;
        // a response landing with the redirect is dropped on the spot; otherwise it must be swallowed later
        w_state_nx = i_imem_rvalid ? S_REQ : S_DISCARD;
      end else if (i_imem_rvalid) begin
        w_push     = 1'b1;
        w_pc_nx    = r_pc + 32'd1;
        w_state_nx = S_REQ;
      end
      S_DISCARD: begin
        if (i_redirect) begin
          w_flush = 1'b1;
          w_pc_nx = i_redirect_pc;
        end
        if (i_imem_rvalid) w_state_nx = S_REQ;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= BOOT_PC;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      if (w_flush) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        r_wr  <= w_push ? r_wr + AW'(1) : r_wr;
        r_rd  <= w_pop ? r_rd + AW'(1) : r_rd;
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  // storage needs no reset: reads are masked by the count
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_data[r_wr] <= i_imem_rdata;
      r_ipc[r_wr]  <= r_pc;
    end
  end
  assign o_inst_valid = !w_empty;
  assign o_inst       = w_empty ? 32'h0 : r_data[r_rd];
  assign o_inst_pc    = w_empty ? 32'h0 : r_ipc[r_rd];
  assign o_imem_req   = w_req;
  assign o_imem_addr  = w_req ? r_pc : 32'h0;
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(w_push && !w_pop && w_full));
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized check of inst_fetch against a queue-based reference model
module tb_inst_fetch;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] BOOT_PC = 32'h0;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_redirect = 1'b0, i_consume = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic [31:0] o_inst, o_inst_pc, o_imem_addr;
  logic        o_inst_valid, o_imem_req;
  always #5 clk = ~clk;
  inst_fetch #(.DEPTH(DEPTH), .BOOT_PC(BOOT_PC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .i_consume(i_consume), .o_inst(o_inst),
    .o_inst_valid(o_inst_valid), .o_inst_pc(o_inst_pc), .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata)
  );
  typedef struct {logic [31:0] pc; logic [31:0] d;} ent_t;
  ent_t        q[$];
  bit          m_run, m_busy, m_drop;
  logic [31:0] m_pc;
  bit          mem_pend;
  int          mem_wait;
  logic [31:0] mem_addr;
  int          lat_lo = 1, lat_hi = 1;
  int          n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_run = 0; m_busy = 0; m_drop = 0; m_pc = BOOT_PC; mem_pend = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_inst_valid), 32'h0);
    chk({tag, "_inst"}, o_inst, 32'h0);
    chk({tag, "_pc"}, o_inst_pc, 32'h0);
    chk({tag, "_req"}, 32'(o_imem_req), 32'h0);
    chk({tag, "_addr"}, o_imem_addr, 32'h0);
  endtask
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc, input bit cons, input bit stray);
    bit          rv, exp_req, resp, take;
    logic [31:0] rdat;
    ent_t        e;
    @(negedge clk);
    rv = 0; rdat = $urandom;
    if (mem_pend) begin
      mem_wait--;
      if (mem_wait == 0) begin
        rv = 1; rdat = mem_addr + 32'h100; mem_pend = 0;
      end
    end else if (stray && !m_busy) rv = 1;
    i_start = st; i_redirect = rd; i_redirect_pc = rpc; i_consume = cons;
    i_imem_rvalid = rv; i_imem_rdata = rdat;
    #1;
    exp_req = m_run && !m_busy && !rd && q.size() < DEPTH;
    chk("valid", 32'(o_inst_valid), 32'(q.size() != 0));
    chk("inst", o_inst, q.size() != 0 ? q[0].d : 32'h0);
    chk("inst_pc", o_inst_pc, q.size() != 0 ? q[0].pc : 32'h0);
    chk("req", 32'(o_imem_req), 32'(exp_req));
    chk("addr", o_imem_addr, exp_req ? m_pc : 32'h0);
    if (o_imem_req) begin
      mem_pend = 1; mem_wait = $urandom_range(lat_hi, lat_lo); mem_addr = o_imem_addr;
    end
    if (!m_run) begin
      if (st) begin m_run = 1; m_pc = BOOT_PC; end
    end else begin
      resp = m_busy && rv;
      take = resp && !m_drop && !rd;
      if (rd) begin
        q.delete(); m_pc = rpc;
        if (m_busy && !resp) m_drop = 1;
      end else begin
        if (cons && q.size() != 0) void'(q.pop_front());
        if (take) begin e.pc = m_pc; e.d = rdat; q.push_back(e); m_pc = m_pc + 1; end
        if (exp_req) m_busy = 1;
      end
      if (resp) begin m_busy = 0; m_drop = 0; end
    end
  endtask
  task automatic run(input int n, input int pcons, input int pred, input int pstray);
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom_range(255);
      cycle(0, $urandom_range(99) < pred, rpc, $urandom_range(99) < pcons, $urandom_range(99) < pstray);
    end
  endtask
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    i_start = 0; i_redirect = 0; i_consume = 0; i_imem_rvalid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    // idle: redirect, consume and stray rvalid must all be ignored
    for (int i = 0; i < 6; i++) cycle(0, i[0], 32'h40, 1, 1);
    // fill with 1-cycle memory and no consume
    lat_lo = 1; lat_hi = 1;
    cycle(1, 0, 0, 0, 0);
    run(20, 0, 0, 0);
    chk("full_valid", 32'(o_inst_valid), 32'h1);
    chk("full_pc", o_inst_pc, 32'h0);
    chk("full_inst", o_inst, 32'h100);
    // consume every cycle, 2-cycle memory
    lat_lo = 2; lat_hi = 2;
    run(30, 100, 0, 0);
    // mixed random traffic with redirects and stray responses
    lat_lo = 1; lat_hi = 3;
    run(400, 40, 8, 20);
    lat_lo = 1; lat_hi = 1;
    run(300, 50, 5, 10);
    lat_lo = 2; lat_hi = 4;
    run(300, 70, 15, 20);
    // reset while a request is outstanding, then a stray response
    for (int i = 0; i < 50 && !m_busy; i++) run(1, 30, 0, 0);
    chk("busy_before_rst", 32'(m_busy), 32'h1);
    async_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1);
    chk_zero("post_rst");
    cycle(1, 0, 0, 0, 0);
    lat_lo = 1; lat_hi = 3;
    run(400, 50, 10, 20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
